// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the arbiter, the bus mux and both master front-ends.
//   SEL_*        : bus mux select encodings carried on master_sel
//   arb_state_e  : arbiter FSM state encoding
package i2c_pkg;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_EEPROM = 2'b01;
    localparam logic [1:0] SEL_OLED   = 2'b10;

    typedef enum logic [1:0] {
        ArbIdle      = 2'b00,
        ArbGntEeprom = 2'b01,
        ArbGntOled   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/i2c_arbiter.sv
// Non-preemptive two-master arbiter for the shared I2C bus.
// The current owner keeps the bus until it drops its request; a waiting master
// is handed the bus on the same edge the owner's request drop is sampled.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   eeprom_req   : EEPROM master request (level)
//   oled_req     : OLED master request (level)
//   eeprom_grant : EEPROM owns the bus
//   oled_grant   : OLED owns the bus
//   master_sel   : bus mux select (00 none, 01 EEPROM, 10 OLED)
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned FIRST_PRIO = 0  // winner of a simultaneous request: 0 EEPROM, 1 OLED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eeprom_req,
    input  logic       oled_req,
    output logic       eeprom_grant,
    output logic       oled_grant,
    output logic [1:0] master_sel
);

    arb_state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ArbIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ArbIdle: begin
                if (eeprom_req && oled_req) begin
                    state_d = (FIRST_PRIO == 0) ? ArbGntEeprom : ArbGntOled;
                end else if (eeprom_req) begin
                    state_d = ArbGntEeprom;
                end else if (oled_req) begin
                    state_d = ArbGntOled;
                end
            end
            ArbGntEeprom: begin
                if (!eeprom_req) begin
                    state_d = oled_req ? ArbGntOled : ArbIdle;
                end
            end
            ArbGntOled: begin
                if (!oled_req) begin
                    state_d = eeprom_req ? ArbGntEeprom : ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    // Outputs depend on state only, so reset clears them without waiting for an edge.
    always_comb begin
        eeprom_grant = 1'b0;
        oled_grant   = 1'b0;
        master_sel   = SEL_NONE;
        case (state_q)
            ArbGntEeprom: begin
                eeprom_grant = 1'b1;
                master_sel   = SEL_EEPROM;
            end
            ArbGntOled: begin
                oled_grant = 1'b1;
                master_sel = SEL_OLED;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

    logic       clk;
    logic       reset;
    logic       eeprom_req;
    logic       oled_req;
    logic       eg0, og0, eg1, og1;
    logic [1:0] sel0, sel1;

    int unsigned n_checks;
    int unsigned n_errors;

    i2c_arbiter #(.FIRST_PRIO(0)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .eeprom_req   (eeprom_req),
        .oled_req     (oled_req),
        .eeprom_grant (eg0),
        .oled_grant   (og0),
        .master_sel   (sel0)
    );

    i2c_arbiter #(.FIRST_PRIO(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .eeprom_req   (eeprom_req),
        .oled_req     (oled_req),
        .eeprom_grant (eg1),
        .oled_grant   (og1),
        .master_sel   (sel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {eeprom_grant, oled_grant, master_sel} packed for compact comparisons
    function automatic logic [3:0] outs0();
        return {eg0, og0, sel0};
    endfunction

    function automatic logic [3:0] outs1();
        return {eg1, og1, sel1};
    endfunction

    // Reference next-state on the sel encoding (00 idle, 01 EEPROM, 10 OLED)
    function automatic logic [1:0] model_next(input logic [1:0] cur, input logic e, input logic o,
                                              input bit prio_oled);
        case (cur)
            2'b01:   return e ? 2'b01 : (o ? 2'b10 : 2'b00);
            2'b10:   return o ? 2'b10 : (e ? 2'b01 : 2'b00);
            default: begin
                if (e && o) return prio_oled ? 2'b10 : 2'b01;
                if (e)      return 2'b01;
                if (o)      return 2'b10;
                return 2'b00;
            end
        endcase
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] IDLE_O = 4'b0000;
    localparam logic [3:0] EEP_O  = 4'b1001;
    localparam logic [3:0] OLED_O = 4'b0110;

    initial begin
        logic [1:0] m0, m1;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        eeprom_req = 1'b1;
        oled_req   = 1'b1;

        // Reset held with both requests active
        #200;
        check("reset_hold_dut0", outs0(), IDLE_O);
        check("reset_hold_dut1", outs1(), IDLE_O);
        @(negedge clk);
        eeprom_req = 1'b0;
        oled_req   = 1'b0;
        reset      = 1'b1;
        edge_sample();
        check("idle_after_release", outs0(), IDLE_O);
        edge_sample();
        check("idle_stays", outs0(), IDLE_O);

        // Single OLED request; nothing combinational before the edge
        @(negedge clk);
        oled_req = 1'b1;
        #1;
        check("no_comb_grant", outs0(), IDLE_O);
        edge_sample();
        check("oled_grant", outs0(), OLED_O);

        // EEPROM request does not preempt
        @(negedge clk);
        eeprom_req = 1'b1;
        edge_sample();
        check("no_preempt_1", outs0(), OLED_O);
        edge_sample();
        check("no_preempt_2", outs0(), OLED_O);

        // Handover OLED -> EEPROM in one edge
        @(negedge clk);
        oled_req = 1'b0;
        #1;
        check("handover_pre_edge", outs0(), OLED_O);
        edge_sample();
        check("handover_dut0", outs0(), EEP_O);
        check("handover_dut1", outs1(), EEP_O);

        // Drop EEPROM -> idle
        @(negedge clk);
        eeprom_req = 1'b0;
        edge_sample();
        check("release_idle", outs0(), IDLE_O);

        // Simultaneous requests from idle after a fresh reset
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        eeprom_req = 1'b1;
        oled_req   = 1'b1;
        reset      = 1'b1;
        edge_sample();
        check("simul_prio0", outs0(), EEP_O);
        check("simul_prio1", outs1(), OLED_O);

        // Mid-ownership asynchronous reset
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_dut0", outs0(), IDLE_O);
        check("async_reset_dut1", outs1(), IDLE_O);
        eeprom_req = 1'b0;
        oled_req   = 1'b1;
        @(negedge clk);
        check("reset_held_edge", outs0(), IDLE_O);
        reset = 1'b1;
        edge_sample();
        check("post_reset_oled", outs0(), OLED_O);

        // One-cycle request glitch still gets a one-cycle grant
        @(negedge clk);
        oled_req = 1'b0;
        edge_sample();
        check("back_idle", outs0(), IDLE_O);
        @(negedge clk);
        eeprom_req = 1'b1;
        edge_sample();
        check("glitch_grant", outs0(), EEP_O);
        @(negedge clk);
        eeprom_req = 1'b0;
        edge_sample();
        check("glitch_release", outs0(), IDLE_O);

        // Random request streams against the reference model
        m0 = 2'b00;
        m1 = 2'b00;
        for (int i = 0; i < 10000; i++) begin
            logic e, o;
            @(negedge clk);
            e = ($urandom_range(0, 3) != 0) ? ~eeprom_req : eeprom_req;
            o = ($urandom_range(0, 3) != 0) ? ~oled_req : oled_req;
            if ($urandom_range(0, 1) == 0) begin
                e = eeprom_req;
            end
            eeprom_req = e;
            oled_req   = o;
            m0 = model_next(m0, e, o, 1'b0);
            m1 = model_next(m1, e, o, 1'b1);
            edge_sample();
            check("rand_model_dut0", sel0, m0);
            check("rand_model_dut1", sel1, m1);
            check("rand_grant_sel0", {og0, eg0}, sel0);
            check("rand_grant_sel1", {og1, eg1}, sel1);
            check("rand_overlap0", eg0 & og0, 1'b0);
            check("rand_overlap1", eg1 & og1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Two-master arbiter for the shared I2C bus: the EEPROM controller and the OLED controller each request the bus, and exactly one is granted at a time.
- Sits between the two I2C master front-ends and the bus mux.
- master_sel drives the SDA/SCL mux select; the grant outputs tell each master it owns the bus.
- Non-preemptive: the owner keeps the bus until it drops its request.

Parameters:
- FIRST_PRIO, default 0, master that wins a simultaneous request from IDLE (0 = EEPROM, 1 = OLED).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- eeprom_req  input  1  EEPROM master bus request, level; held high for the whole transaction.
- oled_req  input  1  OLED master bus request, level; held high for the whole transaction.
- eeprom_grant  output  1  EEPROM owns the bus.
- oled_grant  output  1  OLED owns the bus.
- master_sel  output  2  bus mux select: 2'b00 = none, 2'b01 = EEPROM, 2'b10 = OLED; 2'b11 is never driven.

Behaviour:
- States: IDLE, GNT_EEPROM, GNT_OLED. Use a registered state with one-hot or binary encoding.
- Reset: while reset = 0, asynchronously force IDLE, eeprom_grant = 0, oled_grant = 0, master_sel = 2'b00. Leave reset synchronously at the first clk edge after reset returns to 1.
- Outputs are decoded purely from state:
  - IDLE -> 0 / 0 / 00.
  - GNT_EEPROM -> eeprom_grant = 1, master_sel = 01.
  - GNT_OLED -> oled_grant = 1, master_sel = 10.
- Invariants: at most one grant is high at any time, and master_sel always matches the active grant.
- From IDLE:
  - eeprom_req only -> GNT_EEPROM.
  - oled_req only -> GNT_OLED.
  - Both requests -> the master selected by FIRST_PRIO (default EEPROM).
  - Neither request -> stay in IDLE.
- In GNT_EEPROM:
  - Stay while eeprom_req = 1; the oled_req value is ignored (no preemption).
  - When eeprom_req = 0: go to GNT_OLED if oled_req = 1, otherwise go to IDLE.
- In GNT_OLED: symmetric to GNT_EEPROM.
- Handover rules:
  - Direct owner-to-owner transfer takes one clock.
  - Grants never overlap.
  - No idle gap is required.
- Latency:
  - Request sampled at edge N -> grant high after edge N.
  - Request drop sampled at edge N -> grant low after edge N.
  - The arbiter never grants combinationally.
- Requests asserted during reset are ignored. Arbitration evaluates them at the first edge after reset release.
- A reset mid-ownership drops the grant immediately and asynchronously. There is no memory of the prior owner.
- A request glitch of one cycle still yields a one-cycle grant; the master is responsible for holding its request.

Decomposition:
- Shared package i2c_pkg holds:
  - master_sel encodings: SEL_NONE = 2'b00, SEL_EEPROM = 2'b01, SEL_OLED = 2'b10.
  - The arbiter state enum.
- These constants are reused by the bus mux and both master front-ends.
- No sub-module: a single FSM with a next-state block and an output decode block.

Test Plan:
- Reset: hold reset = 0 for 200 ns with any request values -> eeprom_grant = 0, oled_grant = 0, master_sel = 00. After release with no requests -> outputs stay 0.
- Single OLED request: oled_req = 1, eeprom_req = 0 -> after 1 edge oled_grant = 1, master_sel = 10. Then raise eeprom_req while oled_req stays 1 -> no change (no preemption).
- Handover: from GNT_OLED with both requesting, drop oled_req -> next edge oled_grant = 0, eeprom_grant = 1, master_sel = 01, no overlap cycle. Drop eeprom_req -> next edge IDLE, master_sel = 00.
- Simultaneous from IDLE: after reset, raise eeprom_req = oled_req = 1 on the same cycle -> eeprom_grant = 1, master_sel = 01 (FIRST_PRIO = 0). With FIRST_PRIO = 1 -> oled_grant = 1, master_sel = 10.
- Mid-ownership reset: in GNT_EEPROM, assert reset = 0 between clock edges -> grants and master_sel clear immediately, without waiting for a clock edge. On release with only oled_req = 1 -> GNT_OLED after 1 edge.
- Random assertion run: random request streams for 10k cycles -> never both grants high, master_sel never 11, master_sel always consistent with the grants, and the owner never changes while its request is high.
